ac_register_bank: RTL and testbench
===================================

Name: ac_register_bank

Overview:
Parametrised multi-entry accumulator register bank. It replaces the single 24-bit AC register in the datapath with NUM_REGS independent accumulators. Each accumulator supports clear, increment, load from memory data, load from ALU result, and in-place accumulate. Accumulate and increment have a selectable wrap or saturate mode, and each accumulator has a sticky overflow flag. Sits between the memory data bus / ALU output and the ALU operand input; the control unit drives it.

Parameters:
WIDTH, 24, accumulator word width in bits (>=2)
NUM_REGS, 4, number of accumulators (1..16)
INC_STEP, 1, unsigned amount added by incre (< 2^WIDTH)
SATURATE, 0, 0 = modulo-2^WIDTH wrap on add/increment; 1 = clamp to all-ones
SEL_W, derived, max(1, ceil(log2(NUM_REGS))); not user-set

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-low reset
wr_sel  in  SEL_W  accumulator targeted by this cycle's operation
rd_sel  in  SEL_W  accumulator driven on data_out/zero/ovf
clear  in  1  zero accumulator wr_sel and its overflow flag
incre  in  1  acc[wr_sel] += INC_STEP
write_en  in  1  acc[wr_sel] <= data_in
alu_to_ac  in  1  acc[wr_sel] <= alu_out
acc_en  in  1  acc[wr_sel] += data_in
data_in  in  WIDTH  memory/data bus operand
alu_out  in  WIDTH  ALU result
data_out  out  WIDTH  acc[rd_sel]
zero  out  1  data_out == 0
ovf  out  1  sticky overflow flag of acc[rd_sel]
ovf_any  out  1  OR of all sticky overflow flags

Behaviour:
- Reset: synchronous, active-low. Sampled at the rising edge of clk while rst==0. All accumulators and all overflow flags go to 0.
- Outputs after reset: data_out=0, zero=1, ovf=0, ovf_any=0.
- Reset overrides any operation in the same cycle, including mid-sequence.
- Per-cycle command priority: rst > clear > incre > write_en > alu_to_ac > acc_en. Exactly one operation executes per cycle, on acc[wr_sel] only; lower-priority requests that cycle are dropped.
- No strobe asserted: all accumulators hold.
- Arithmetic: unsigned, computed at WIDTH+1 bits. Carry-out = bit WIDTH.
  - SATURATE=0: result = low WIDTH bits.
  - SATURATE=1: on carry, result = 2^WIDTH-1.
  - Either mode: carry sets ovf flag of acc[wr_sel], which stays set until clear or rst.
- Loads (write_en, alu_to_ac) never change the overflow flag.
- clear zeroes both the accumulator and its flag.
- Read side is combinational from state, with no read latency:
  - data_out = acc[rd_sel]; zero and ovf follow rd_sel.
  - An operation on acc[rd_sel] becomes visible on data_out the cycle after the edge (old value while the strobe is high).
- Out-of-range select (NUM_REGS not a power of two):
  - wr_sel >= NUM_REGS: operation is ignored, no state change.
  - rd_sel >= NUM_REGS: data_out=0, zero=1, ovf=0.
- NUM_REGS=1: selects are ignored, acc[0] is always used. With WIDTH=24, INC_STEP=1, SATURATE=0, the block then behaves as the legacy single AC register plus acc_en/clear/flags.
- Back-to-back operations on the same accumulator each see the previous cycle's result (no hazards, no stalls).
- Strobes for different accumulators cannot coexist in a cycle: single write port.

Test Plan:
- Reset with rst=0 for 2 cycles while write_en=1, data_in=0xABCDEF -> all acc=0, data_out=0, zero=1, ovf_any=0 after release.
- wr_sel=2, write_en=1, data_in=0x123456; next cycle rd_sel=2 -> data_out=0x123456, zero=0; rd_sel=1 -> data_out=0.
- Priority: wr_sel=0, incre=1, write_en=1, alu_to_ac=1, data_in=0x10, alu_out=0x20, acc0 previously 5 -> acc0=6. Next cycle clear=1, incre=1 -> acc0=0.
- Wrap mode (SATURATE=0): acc1=0xFFFFFE, acc_en=1, data_in=3 -> acc1=0x000001, ovf=1 on rd_sel=1, ovf_any=1. Then write_en with data_in=7 -> acc1=7, ovf still 1. Then clear -> acc1=0, ovf=0.
- Saturate build (SATURATE=1): acc3=0xFFFFFF, incre for 3 cycles -> acc3 stays 0xFFFFFF, ovf=1. acc_en with data_in=0 -> unchanged.
- NUM_REGS=3 build: wr_sel=3, write_en=1, data_in=0x55 -> no accumulator changes. rd_sel=3 -> data_out=0, zero=1. Assert rst=0 during a 4-cycle incre burst on acc0 -> acc0=0 the cycle after reset, counting resumes from 0 on release.

Source files
------------

// File: rtl/ac_register_bank_if.sv
// Accumulator bank command/read bundle.
// Control unit drives commands; the bank returns the selected entry.
interface ac_register_bank_if #(
    parameter int WIDTH    = 24,
    parameter int NUM_REGS = 4
);
    localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [SEL_W-1:0] wr_sel;
    logic [SEL_W-1:0] rd_sel;
    logic             clear;
    logic             incre;
    logic             write_en;
    logic             alu_to_ac;
    logic             acc_en;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] data_out;
    logic             zero;
    logic             ovf;
    logic             ovf_any;

    modport master (
        output wr_sel, rd_sel, clear, incre, write_en,
        output alu_to_ac, acc_en, data_in, alu_out,
        input  data_out, zero, ovf, ovf_any
    );

    modport slave (
        input  wr_sel, rd_sel, clear, incre, write_en,
        input  alu_to_ac, acc_en, data_in, alu_out,
        output data_out, zero, ovf, ovf_any
    );
endinterface

// File: rtl/ac_register_bank.sv
// Multi-entry accumulator bank with wrap/saturate add and sticky
// per-entry overflow flags; single write port, combinational read.
module ac_register_bank #(
    parameter int WIDTH    = 24,
    parameter int NUM_REGS = 4,
    parameter int INC_STEP = 1,
    parameter int SATURATE = 0
) (
    input  logic               clk,
    input  logic               rst,
    ac_register_bank_if.slave  bus
);
    localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [WIDTH-1:0]    acc [NUM_REGS];
    logic [NUM_REGS-1:0] ovf_q;
    logic [NUM_REGS-1:0] wr_hit;
    logic [NUM_REGS-1:0] rd_hit;
    logic [WIDTH-1:0]    wr_cur;
    logic [WIDTH-1:0]    rd_val;
    logic [WIDTH-1:0]    addend;
    logic [WIDTH-1:0]    add_res;
    logic [WIDTH:0]      sum;
    logic [WIDTH-1:0]    nxt;
    logic                upd;
    logic                clr;
    logic                set_ovf;

    // Out-of-range selects match no entry, so they neither write nor read.
    always_comb begin
        wr_hit = '0;
        rd_hit = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_hit[i] = (NUM_REGS == 1) || (bus.wr_sel == SEL_W'(i));
            rd_hit[i] = (NUM_REGS == 1) || (bus.rd_sel == SEL_W'(i));
        end
    end

    always_comb begin
        wr_cur = '0;
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_hit[i]) wr_cur = acc[i];
            if (rd_hit[i]) rd_val = acc[i];
        end
    end

    assign addend  = bus.incre ? WIDTH'(INC_STEP) : bus.data_in;
    assign sum     = {1'b0, wr_cur} + {1'b0, addend};
    assign add_res = (SATURATE != 0 && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];

    always_comb begin
        upd     = 1'b1;
        clr     = 1'b0;
        set_ovf = 1'b0;
        nxt     = wr_cur;
        priority case (1'b1)
            bus.clear: begin
                nxt = '0;
                clr = 1'b1;
            end
            bus.incre: begin
                nxt     = add_res;
                set_ovf = sum[WIDTH];
            end
            bus.write_en:  nxt = bus.data_in;
            bus.alu_to_ac: nxt = bus.alu_out;
            bus.acc_en: begin
                nxt     = add_res;
                set_ovf = sum[WIDTH];
            end
            default: upd = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) acc[i] <= '0;
            ovf_q <= '0;
        end else if (upd) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_hit[i]) begin
                    acc[i] <= nxt;
                    if (clr)          ovf_q[i] <= 1'b0;
                    else if (set_ovf) ovf_q[i] <= 1'b1;
                end
            end
        end
    end

    assign bus.data_out = rd_val;
    assign bus.zero     = (rd_val == '0);
    assign bus.ovf      = |(ovf_q & rd_hit);
    assign bus.ovf_any  = |ovf_q;
endmodule

// File: tb/tb_ac_register_bank.sv
// Three bank builds (wrap, saturate, 3-entry) driven by one command
// stream and compared against an arithmetic reference model.
module tb_ac_register_bank;
    localparam int W = 24;
    localparam logic [W-1:0] MAXV = 24'hFFFFFF;
    localparam logic [4:0] CLR = 5'b10000;
    localparam logic [4:0] INC = 5'b01000;
    localparam logic [4:0] WE  = 5'b00100;
    localparam logic [4:0] ALU = 5'b00010;
    localparam logic [4:0] ACC = 5'b00001;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [1:0] wr_sel = '0;
    logic [1:0] rd_sel = '0;
    logic clear = 0, incre = 0, write_en = 0, alu_to_ac = 0, acc_en = 0;
    logic [W-1:0] data_in = '0;
    logic [W-1:0] alu_out = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ac_register_bank_if #(.WIDTH(W), .NUM_REGS(4)) b0 ();
    ac_register_bank_if #(.WIDTH(W), .NUM_REGS(4)) b1 ();
    ac_register_bank_if #(.WIDTH(W), .NUM_REGS(3)) b2 ();

    assign {b0.wr_sel, b0.rd_sel, b0.clear, b0.incre, b0.write_en,
            b0.alu_to_ac, b0.acc_en, b0.data_in, b0.alu_out} =
           {wr_sel, rd_sel, clear, incre, write_en,
            alu_to_ac, acc_en, data_in, alu_out};
    assign {b1.wr_sel, b1.rd_sel, b1.clear, b1.incre, b1.write_en,
            b1.alu_to_ac, b1.acc_en, b1.data_in, b1.alu_out} =
           {wr_sel, rd_sel, clear, incre, write_en,
            alu_to_ac, acc_en, data_in, alu_out};
    assign {b2.wr_sel, b2.rd_sel, b2.clear, b2.incre, b2.write_en,
            b2.alu_to_ac, b2.acc_en, b2.data_in, b2.alu_out} =
           {wr_sel, rd_sel, clear, incre, write_en,
            alu_to_ac, acc_en, data_in, alu_out};

    ac_register_bank #(.WIDTH(W), .NUM_REGS(4), .INC_STEP(1), .SATURATE(0))
        dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
    ac_register_bank #(.WIDTH(W), .NUM_REGS(4), .INC_STEP(3), .SATURATE(1))
        dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
    ac_register_bank #(.WIDTH(W), .NUM_REGS(3), .INC_STEP(1), .SATURATE(0))
        dut2 (.clk(clk), .rst(rst), .bus(b2.slave));

    // Reference model: one row per build.
    int nregs [3] = '{4, 4, 3};
    int step  [3] = '{1, 3, 1};
    bit sat   [3] = '{0, 1, 0};
    logic [W-1:0] m_acc [3][4];
    bit           m_ovf [3][4];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic m_add(input int k, input int w, input longint v);
        longint s;
        s = longint'(m_acc[k][w]) + v;
        if (s > longint'(MAXV)) begin
            m_ovf[k][w] = 1;
            m_acc[k][w] = sat[k] ? MAXV : W'(s - (longint'(1) << W));
        end else begin
            m_acc[k][w] = W'(s);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            if (!rst) begin
                for (int i = 0; i < 4; i++) begin
                    m_acc[k][i] = '0;
                    m_ovf[k][i] = 0;
                end
            end else if (int'(wr_sel) < nregs[k]) begin
                int w = int'(wr_sel);
                if (clear) begin
                    m_acc[k][w] = '0;
                    m_ovf[k][w] = 0;
                end else if (incre)     m_add(k, w, longint'(step[k]));
                else if (write_en)      m_acc[k][w] = data_in;
                else if (alu_to_ac)     m_acc[k][w] = alu_out;
                else if (acc_en)        m_add(k, w, longint'(data_in));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic op(input logic [1:0] s, input logic [4:0] st,
                      input logic [W-1:0] d, input logic [W-1:0] a);
        wr_sel = s;
        {clear, incre, write_en, alu_to_ac, acc_en} = st;
        data_in = d;
        alu_out = a;
        tick();
        {clear, incre, write_en, alu_to_ac, acc_en} = '0;
    endtask

    task automatic obs(input int k, output logic [W-1:0] d,
                       output logic z, output logic o, output logic a);
        case (k)
            0: begin d = b0.data_out; z = b0.zero; o = b0.ovf; a = b0.ovf_any; end
            1: begin d = b1.data_out; z = b1.zero; o = b1.ovf; a = b1.ovf_any; end
            default: begin d = b2.data_out; z = b2.zero; o = b2.ovf; a = b2.ovf_any; end
        endcase
    endtask

    task automatic check_read();
        logic [W-1:0] d, ed;
        logic z, o, a;
        bit eo, ea;
        for (int r = 0; r < 4; r++) begin
            rd_sel = 2'(r);
            #1;
            for (int k = 0; k < 3; k++) begin
                obs(k, d, z, o, a);
                ed = (r < nregs[k]) ? m_acc[k][r] : '0;
                eo = (r < nregs[k]) ? m_ovf[k][r] : 0;
                ea = 0;
                for (int i = 0; i < nregs[k]; i++) ea |= m_ovf[k][i];
                chk($sformatf("k%0d r%0d data", k, r), 32'(d), 32'(ed));
                chk($sformatf("k%0d r%0d zero", k, r), 32'(z), 32'(ed == '0));
                chk($sformatf("k%0d r%0d ovf", k, r), 32'(o), 32'(eo));
                chk($sformatf("k%0d r%0d ovf_any", k, r), 32'(a), 32'(ea));
            end
        end
    endtask

    task automatic lit(input string tag, input int k, input logic [1:0] r,
                       input logic [W-1:0] ed, input logic eo);
        logic [W-1:0] d;
        logic z, o, a;
        rd_sel = r;
        #1;
        obs(k, d, z, o, a);
        chk({tag, " data"}, 32'(d), 32'(ed));
        chk({tag, " zero"}, 32'(z), 32'(ed == '0));
        chk({tag, " ovf"}, 32'(o), 32'(eo));
    endtask

    initial begin
        logic [W-1:0] rv;
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 4; i++) begin
                m_acc[k][i] = 'x;
                m_ovf[k][i] = 0;
            end

        // Reset held two cycles against a pending load.
        rst = 1'b0;
        write_en = 1'b1;
        data_in = 24'hABCDEF;
        tick();
        tick();
        rst = 1'b1;
        write_en = 1'b0;
        lit("rst", 0, 2'd0, '0, 1'b0);
        check_read();

        op(2'd2, WE, 24'h123456, '0);
        lit("ld2", 0, 2'd2, 24'h123456, 1'b0);
        lit("ld2 other", 0, 2'd1, '0, 1'b0);

        op(2'd0, WE, 24'd5, '0);
        op(2'd0, INC | WE | ALU, 24'h10, 24'h20);
        lit("prio", 0, 2'd0, 24'd6, 1'b0);
        lit("prio sat", 1, 2'd0, 24'd8, 1'b0);
        op(2'd0, CLR | INC, '0, '0);
        lit("clr>inc", 0, 2'd0, '0, 1'b0);
        check_read();

        op(2'd1, WE, 24'hFFFFFE, '0);
        op(2'd1, ACC, 24'd3, '0);
        lit("wrap", 0, 2'd1, 24'h000001, 1'b1);
        lit("sat add", 1, 2'd1, MAXV, 1'b1);
        op(2'd1, WE, 24'd7, '0);
        lit("ld keeps ovf", 0, 2'd1, 24'd7, 1'b1);
        op(2'd1, CLR, '0, '0);
        lit("clr ovf", 0, 2'd1, '0, 1'b0);
        check_read();

        op(2'd3, WE, MAXV, '0);
        for (int i = 0; i < 3; i++) op(2'd3, INC, '0, '0);
        lit("sat inc", 1, 2'd3, MAXV, 1'b1);
        op(2'd3, ACC, '0, '0);
        lit("sat add0", 1, 2'd3, MAXV, 1'b1);
        op(2'd3, WE, 24'h55, '0);
        lit("oob rd", 2, 2'd3, '0, 1'b0);
        check_read();

        // Reset in the middle of an increment burst.
        op(2'd0, CLR, '0, '0);
        wr_sel = 2'd0;
        incre = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        lit("burst rst", 2, 2'd0, '0, 1'b0);
        tick();
        lit("burst resume", 2, 2'd0, 24'd1, 1'b0);
        incre = 1'b0;
        check_read();

        for (int n = 0; n < 400; n++) begin
            rv = W'($urandom);
            if ($urandom_range(0, 3) == 0) rv = MAXV - W'($urandom_range(0, 8));
            rst = ($urandom_range(0, 63) != 0);
            op(2'($urandom_range(0, 3)),
               {($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 2) == 0)},
               rv, W'($urandom));
            rst = 1'b1;
            check_read();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
